sar_search_4b: RTL and testbench

Successive-approximation search controller that sits on the opposite side of the 4-bit magnitude comparator. The unknown target drives the comparator `data_a`. This block drives `data_b` with probe values and samples the comparator's `gt`/`eq`/`lt` flags. A binary search recovers the target in at most five probes and reports it with a one-cycle `done` pulse.

---
 rtl/sar_search_pkg.sv | 20 ++
 rtl/sar_step.sv | 48 ++++
 rtl/sar_search_4b.sv | 148 ++++++++++++++
 tb/tb_sar_search_4b.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encoding, comparator flag patterns and default parameters.
package sar_search_pkg;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int DEFAULT_SETTLE = 1;

    // Comparator flags packed as {gt, eq, lt}; a valid sample is exactly one of these.
    localparam logic [2:0] FLAG_GT = 3'b100;
    localparam logic [2:0] FLAG_EQ = 3'b010;
    localparam logic [2:0] FLAG_LT = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } sar_state_e;

endpackage

// File: rtl/sar_step.sv
// One binary-search step: narrows [lo, hi] from the sampled comparator flags
// and proposes the next probe. Purely combinational.
module sar_step
    import sar_search_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] guess,
    input  logic [2:0]       flags,
    output logic [WIDTH-1:0] next_lo,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_guess,
    output logic             hit,
    output logic             exhausted,
    output logic             bad_flags
);

    // One extra bit so lo+hi never wraps before halving.
    logic [WIDTH:0] sum;

    // Decode the flags, shrink the interval, and take its midpoint.
    always_comb begin
        next_lo   = lo;
        next_hi   = hi;
        hit       = 1'b0;
        exhausted = 1'b0;
        bad_flags = 1'b0;
        case (flags)
            FLAG_EQ: hit = 1'b1;
            FLAG_GT: begin
                if (guess == hi) exhausted = 1'b1;
                else             next_lo   = guess + WIDTH'(1);
            end
            FLAG_LT: begin
                // guess==lo also covers guess==0, so guess-1 can never underflow.
                if (guess == lo) exhausted = 1'b1;
                else             next_hi   = guess - WIDTH'(1);
            end
            // 000, multi-hot and unknown flag patterns all land here.
            default: bad_flags = 1'b1;
        endcase
        sum        = {1'b0, next_lo} + {1'b0, next_hi};
        next_guess = WIDTH'(sum >> 1);
    end

endmodule

// File: rtl/sar_search_4b.sv
// Successive-approximation search controller. Drives probe values into a
// magnitude comparator (guess -> data_b) and binary-searches the unknown
// target from the gt/eq/lt flags, reporting with a one-cycle done pulse.
//
// Handshake: start is a request without a ready; it is taken only on an edge
// where the FSM is in IDLE (busy=0 and done=0). A start seen in any other
// state is dropped, never queued. done pulses for exactly one cycle, and
// result/found/err are valid from that cycle until the next accepted start.
module sar_search_4b
    import sar_search_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SETTLE = DEFAULT_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err,
    output logic [1:0]       state_dbg
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] MID_VAL = MAX_VAL >> 1;

    sar_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d, result_q, result_d;
    logic             found_q, found_d, err_q, err_d;

    logic [WIDTH-1:0] step_lo, step_hi, step_guess;
    logic             step_hit, step_exh, step_bad;

    sar_step #(.WIDTH(WIDTH)) u_step (
        .lo         (lo_q),
        .hi         (hi_q),
        .guess      (guess_q),
        .flags      ({gt, eq, lt}),
        .next_lo    (step_lo),
        .next_hi    (step_hi),
        .next_guess (step_guess),
        .hit        (step_hit),
        .exhausted  (step_exh),
        .bad_flags  (step_bad)
    );

    // FSM state register; async reset aborts any search in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Search datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath-next logic; everything holds unless a state acts.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    lo_d    = '0;
                    hi_d    = MAX_VAL;
                    guess_d = MID_VAL;
                    found_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_WAIT: begin
                // Probe has been held SETTLE cycles once the count reaches SETTLE-1.
                if (cnt_q == CW'(SETTLE - 1)) state_d = S_EVAL;
                else                          cnt_d   = cnt_q + CW'(1);
            end
            S_EVAL: begin
                if (step_bad) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = guess_q;
                    state_d  = S_DONE;
                end else if (step_hit) begin
                    found_d  = 1'b1;
                    result_d = guess_q;
                    state_d  = S_DONE;
                end else if (step_exh) begin
                    found_d  = 1'b0;
                    result_d = guess_q;
                    state_d  = S_DONE;
                end else begin
                    lo_d    = step_lo;
                    hi_d    = step_hi;
                    guess_d = step_guess;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status decoded from the registered state, so it is glitch-free.
    always_comb begin
        busy      = (state_q == S_WAIT) || (state_q == S_EVAL);
        done      = (state_q == S_DONE);
        guess     = guess_q;
        result    = result_q;
        found     = found_q;
        err       = err_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_sar_search_4b.sv
// Bench for sar_search_4b: a SETTLE=1 instance with an ideal (or forced)
// comparator driven from a vector table, plus a SETTLE=3 instance behind a
// delayed comparator swept over every target.
module tb_sar_search_4b;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic clk2 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk  = ~clk;
    always #1 clk2 = ~clk2;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- DUT 1: SETTLE=1, ideal or forced flags ----------------
    logic       start = 1'b0;
    logic [3:0] target = 4'd0;
    logic       fen = 1'b0;
    logic [2:0] fflags = 3'b000;
    logic [3:0] guess, result;
    logic       gt, eq, lt, busy, done, found, err;
    logic [1:0] state_dbg;

    assign gt = fen ? fflags[2] : (target > guess);
    assign eq = fen ? fflags[1] : (target == guess);
    assign lt = fen ? fflags[0] : (target < guess);

    sar_search_4b #(.WIDTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .guess(guess),
        .gt(gt), .eq(eq), .lt(lt), .busy(busy), .done(done),
        .result(result), .found(found), .err(err), .state_dbg(state_dbg)
    );

    // ---------------- DUT 2: SETTLE=3, comparator with propagation delay ----------------
    logic       start2 = 1'b0;
    logic [3:0] target2 = 4'd0;
    logic [3:0] guess2, result2;
    logic       gt2 = 1'b0, eq2 = 1'b0, lt2 = 1'b0;
    logic       busy2, done2, found2, err2;
    logic [1:0] state_dbg2;

    always @(guess2 or target2) begin
        gt2 <= #3 (target2 > guess2);
        eq2 <= #4 (target2 == guess2);
        lt2 <= #3 (target2 < guess2);
    end

    sar_search_4b #(.WIDTH(4), .SETTLE(3)) dut2 (
        .clk(clk2), .rst_n(rst_n), .start(start2), .guess(guess2),
        .gt(gt2), .eq(eq2), .lt(lt2), .busy(busy2), .done(done2),
        .result(result2), .found(found2), .err(err2), .state_dbg(state_dbg2)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  target;
        logic        fen;
        logic [2:0]  fflags;
        int          poke;       // cycle after start at which start is re-pulsed, -1 = none
        int          exp_cycles; // cycles from accepting edge to done
        int          exp_probes;
        logic [19:0] exp_g;      // probe sequence, first probe in [3:0]
        logic [3:0]  exp_result;
        logic        exp_found;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver: one search on DUT 1 ----------------
    task automatic run_vec(input int idx, input vec_t v);
        int          n;
        int          k;
        logic [19:0] seen;
        n = 0;
        k = 0;
        seen = '0;
        @(negedge clk);
        target = v.target;
        fen    = v.fen;
        fflags = v.fflags;
        start  = 1'b1;
        @(negedge clk);  // accepting edge E0 has passed
        check($sformatf("v%0d busy_after_start", idx), busy, 1);
        while (n < 40 && !done) begin
            if (n % 2 == 0 && k < 5) begin
                seen[k*4 +: 4] = guess;
                k++;
            end
            start = (n == v.poke);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (n >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL v%0d timeout: no done within 40 cycles", idx);
        end
        check($sformatf("v%0d cycles", idx), n, v.exp_cycles);
        check($sformatf("v%0d probes", idx), k, v.exp_probes);
        for (int i = 0; i < v.exp_probes && i < k; i++)
            check($sformatf("v%0d probe%0d", idx, i), seen[i*4 +: 4], v.exp_g[i*4 +: 4]);
        check($sformatf("v%0d result", idx), result, v.exp_result);
        check($sformatf("v%0d found", idx), found, v.exp_found);
        check($sformatf("v%0d err", idx), err, v.exp_err);
        check($sformatf("v%0d busy_at_done", idx), busy, 0);
        @(negedge clk);
        check($sformatf("v%0d done_one_cycle", idx), done, 0);
        check($sformatf("v%0d idle_after", idx), state_dbg, 2'd0);
        check($sformatf("v%0d result_holds", idx), result, v.exp_result);
        check($sformatf("v%0d found_holds", idx), found, v.exp_found);
    endtask

    // ---------------- driver: one search on DUT 2 ----------------
    task automatic run_sweep(input logic [3:0] t);
        int n;
        n = 0;
        @(negedge clk2);
        target2 = t;
        @(negedge clk2);
        start2 = 1'b1;
        @(negedge clk2);
        start2 = 1'b0;
        while (n < 60 && !done2) begin
            @(negedge clk2);
            n++;
        end
        if (n >= 60) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sweep t=%0d timeout: no done within 60 cycles", t);
        end
        check($sformatf("sweep t=%0d found", t), found2, 1);
        check($sformatf("sweep t=%0d result", t), result2, t);
        check($sformatf("sweep t=%0d err", t), err2, 0);
        check($sformatf("sweep t=%0d probe_count_ok", t), (n % 4 == 0) && (n >= 4) && (n <= 20), 1);
        @(negedge clk2);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        //            target fen  flags  poke cyc prb  probes      res  fnd err
        vecs[0]  = '{4'd7,  1'b0, 3'b000, -1, 2,  1, 20'h00007, 4'd7,  1'b1, 1'b0};
        vecs[1]  = '{4'd15, 1'b0, 3'b000, -1, 10, 5, 20'hFEDB7, 4'd15, 1'b1, 1'b0};
        vecs[2]  = '{4'd0,  1'b0, 3'b000, -1, 8,  4, 20'h00137, 4'd0,  1'b1, 1'b0};
        vecs[3]  = '{4'd10, 1'b0, 3'b000, -1, 8,  4, 20'h0A9B7, 4'd10, 1'b1, 1'b0};
        vecs[4]  = '{4'd3,  1'b0, 3'b000, -1, 4,  2, 20'h00037, 4'd3,  1'b1, 1'b0};
        vecs[5]  = '{4'd0,  1'b1, 3'b011, -1, 2,  1, 20'h00007, 4'd7,  1'b0, 1'b1};
        vecs[6]  = '{4'd0,  1'b1, 3'b001, -1, 8,  4, 20'h00137, 4'd0,  1'b0, 1'b0};
        vecs[7]  = '{4'd0,  1'b1, 3'b100, -1, 10, 5, 20'hFEDB7, 4'd15, 1'b0, 1'b0};
        vecs[8]  = '{4'd0,  1'b1, 3'b000, -1, 2,  1, 20'h00007, 4'd7,  1'b0, 1'b1};
        vecs[9]  = '{4'd0,  1'b1, 3'b111, -1, 2,  1, 20'h00007, 4'd7,  1'b0, 1'b1};
        vecs[10] = '{4'd15, 1'b0, 3'b000, 3,  10, 5, 20'hFEDB7, 4'd15, 1'b1, 1'b0};
        vecs[11] = '{4'd12, 1'b0, 3'b000, 0,  8,  4, 20'h0CDB7, 4'd12, 1'b1, 1'b0};

        // reset values
        repeat (2) @(negedge clk);
        check("rst guess", guess, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst result", result, 0);
        check("rst found", found, 0);
        check("rst err", err, 0);
        check("rst state", state_dbg, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // reset dropped mid-search: outputs return to reset values at once
        @(negedge clk);
        fen    = 1'b0;
        target = 4'd15;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst guess", guess, 0);
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst result", result, 0);
        check("midrst found", found, 0);
        check("midrst err", err, 0);
        check("midrst state", state_dbg, 2'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midrst no_done%0d", i), done, 0);
        end
        rst_n = 1'b1;
        run_vec(12, vecs[3]);

        // SETTLE=3 with a delayed comparator: every target must be found
        for (int t = 0; t < 16; t++) run_sweep(4'(t));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // overall guard so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
